ram_sp_param: RTL and testbench

Parametrised synchronous single-port RAM that generalises the 16x8 single-port RAM. Width and depth are configurable, with per-byte write enables and a selectable read-during-write mode. An optional output pipeline register adds one cycle of read latency. A built-in clear engine zero-fills the whole array after reset or on request, so every unwritten location reads as CLEAR_VAL. The block is used as general scratch/buffer storage behind a simple cs/we port.

---
 rtl/ram_sp_param.sv | 143 ++++++++++++++
 tb/tb_ram_sp_param.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_param.sv
// Single-port RAM with byte enables, read-first/write-first mode, optional output register and clear engine.
// Read latency 1 (OUT_REG=0) or 2 cycles; ready=0 while the clear engine runs, when accesses are ignored.
module ram_sp_param #(
  parameter int                 DATA_W    = 8,
  parameter int                 ADDR_W    = 4,
  parameter int                 READ_MODE = 0,
  parameter int                 OUT_REG   = 0,
  parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  clear_req,
  output logic [DATA_W-1:0]     data_out,
  output logic                  rd_valid,
  output logic                  ready,
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic [DATA_W-1:0]   old_word;
  logic [DATA_W-1:0]   merged_word;
  logic [DATA_W-1:0]   rd_word;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdat;

  logic                s1_vld_q, s1_vld_d;
  logic [DATA_W-1:0]   s1_dat_q, s1_dat_d;

  // clear_req wins over a same-cycle access, which is dropped.
  assign accept   = (state_q == ST_IDLE) && cs && !clear_req;
  assign old_word = mem[addr];
  assign rd_word  = (READ_MODE != 0) ? merged_word : old_word;
  assign ready    = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_CLEAR);

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) merged_word[8*i +: 8] = data_in[8*i +: 8];
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdat  = merged_word;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr_q;
      mem_wdat  = CLEAR_VAL;
    end else if (accept && we) begin
      mem_we    = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (clear_req) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    s1_vld_d = accept;
    s1_dat_d = accept ? rd_word : s1_dat_q;
  end

  // The array has no reset; the clear engine initialises it after reset release.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[mem_waddr] <= mem_wdat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      s1_vld_q   <= 1'b0;
      s1_dat_q   <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      s1_vld_q   <= s1_vld_d;
      s1_dat_q   <= s1_dat_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              s2_vld_q, s2_vld_d;
      logic [DATA_W-1:0] s2_dat_q, s2_dat_d;

      // Data already in stage 1 drains normally even if a clear starts.
      always_comb begin
        s2_vld_d = s1_vld_q;
        s2_dat_d = s1_vld_q ? s1_dat_q : s2_dat_q;
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s2_vld_q <= 1'b0;
          s2_dat_q <= '0;
        end else begin
          s2_vld_q <= s2_vld_d;
          s2_dat_q <= s2_dat_d;
        end
      end

      assign data_out = s2_dat_q;
      assign rd_valid = s2_vld_q;
    end else begin : g_noreg
      assign data_out = s1_dat_q;
      assign rd_valid = s1_vld_q;
    end
  endgenerate

endmodule

// File: tb/tb_ram_sp_param.sv
// Bench for ram_sp_param: three configurations share one stimulus stream, checked via per-instance scoreboards.
// A: 8-bit read-first latency 1; B: 8-bit write-first latency 2; C: 16-bit read-first latency 1.
module tb_ram_sp_param;

  logic        clk;
  logic        rst_n;
  logic        cs;
  logic        we;
  logic [1:0]  be;
  logic [3:0]  addr;
  logic [15:0] din;
  logic        clear_req;

  logic [7:0]  dout_a, dout_b;
  logic [15:0] dout_c;
  logic        vld_a, vld_b, vld_c;
  logic        rdy_a, rdy_b, rdy_c;
  logic        bsy_a, bsy_b, bsy_c;

  int checks;
  int errors;

  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  logic [15:0] qc[$];

  typedef struct {
    logic        we;
    logic [1:0]  be;
    logic [3:0]  addr;
    logic [15:0] din;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [15:0] ec;
  } vec_t;

  vec_t vecs[15];

  ram_sp_param #(.DATA_W(8), .ADDR_W(4), .READ_MODE(0), .OUT_REG(0), .CLEAR_VAL(8'h00)) u_a (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .be(be[0:0]), .addr(addr),
    .data_in(din[7:0]), .clear_req(clear_req), .data_out(dout_a), .rd_valid(vld_a),
    .ready(rdy_a), .busy(bsy_a));

  ram_sp_param #(.DATA_W(8), .ADDR_W(4), .READ_MODE(1), .OUT_REG(1), .CLEAR_VAL(8'h00)) u_b (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .be(be[0:0]), .addr(addr),
    .data_in(din[7:0]), .clear_req(clear_req), .data_out(dout_b), .rd_valid(vld_b),
    .ready(rdy_b), .busy(bsy_b));

  ram_sp_param #(.DATA_W(16), .ADDR_W(4), .READ_MODE(0), .OUT_REG(0), .CLEAR_VAL(16'h0000)) u_c (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .be(be), .addr(addr),
    .data_in(din), .clear_req(clear_req), .data_out(dout_c), .rd_valid(vld_c),
    .ready(rdy_c), .busy(bsy_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Pops the scoreboard of every instance that presents a result this cycle.
  task automatic monitor();
    if (vld_a) begin
      if (qa.size() == 0) chk("a_unexpected_valid", 32'd1, 32'd0);
      else chk("a_data", {24'h0, dout_a}, {24'h0, qa.pop_front()});
    end
    if (vld_b) begin
      if (qb.size() == 0) chk("b_unexpected_valid", 32'd1, 32'd0);
      else chk("b_data", {24'h0, dout_b}, {24'h0, qb.pop_front()});
    end
    if (vld_c) begin
      if (qc.size() == 0) chk("c_unexpected_valid", 32'd1, 32'd0);
      else chk("c_data", {16'h0, dout_c}, {16'h0, qc.pop_front()});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic drive(input logic w, input logic [1:0] b, input logic [3:0] a, input logic [15:0] d);
    cs   = 1'b1;
    we   = w;
    be   = b;
    addr = a;
    din  = d;
  endtask

  task automatic push(input logic [7:0] ea, input logic [7:0] eb, input logic [15:0] ec);
    qa.push_back(ea);
    qb.push_back(eb);
    qc.push_back(ec);
  endtask

  task automatic ready_count(input string name);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk(name, {31'h0, rdy_a & rdy_b & rdy_c}, {31'h0, k == 16});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; cs = 1'b0; we = 1'b0; be = 2'b00; addr = '0; din = '0; clear_req = 1'b0;

    vecs[0]  = '{1'b0, 2'b11, 4'h0, 16'h0000, 8'h00, 8'h00, 16'h0000};
    vecs[1]  = '{1'b1, 2'b11, 4'h4, 16'h12AA, 8'h00, 8'hAA, 16'h0000};
    vecs[2]  = '{1'b1, 2'b11, 4'h5, 16'h34BB, 8'h00, 8'hBB, 16'h0000};
    vecs[3]  = '{1'b0, 2'b00, 4'h4, 16'h0000, 8'hAA, 8'hAA, 16'h12AA};
    vecs[4]  = '{1'b0, 2'b00, 4'h5, 16'h0000, 8'hBB, 8'hBB, 16'h34BB};
    vecs[5]  = '{1'b1, 2'b11, 4'h2, 16'h1234, 8'h00, 8'h34, 16'h0000};
    vecs[6]  = '{1'b1, 2'b01, 4'h2, 16'hABCD, 8'h34, 8'hCD, 16'h1234};
    vecs[7]  = '{1'b0, 2'b00, 4'h2, 16'h0000, 8'hCD, 8'hCD, 16'h12CD};
    vecs[8]  = '{1'b1, 2'b00, 4'h2, 16'hFFFF, 8'hCD, 8'hCD, 16'h12CD};
    vecs[9]  = '{1'b0, 2'b00, 4'h2, 16'h0000, 8'hCD, 8'hCD, 16'h12CD};
    vecs[10] = '{1'b1, 2'b11, 4'h7, 16'h0011, 8'h00, 8'h11, 16'h0000};
    vecs[11] = '{1'b1, 2'b11, 4'h7, 16'h0022, 8'h11, 8'h22, 16'h0011};
    vecs[12] = '{1'b0, 2'b00, 4'h7, 16'h0000, 8'h22, 8'h22, 16'h0022};
    vecs[13] = '{1'b1, 2'b10, 4'hF, 16'h5A5A, 8'h00, 8'h00, 16'h0000};
    vecs[14] = '{1'b0, 2'b00, 4'hF, 16'h0000, 8'h00, 8'h00, 16'h5A00};

    // Reset state
    tick();
    tick();
    chk("rst_dout_a", {24'h0, dout_a}, 32'h0);
    chk("rst_dout_b", {24'h0, dout_b}, 32'h0);
    chk("rst_dout_c", {16'h0, dout_c}, 32'h0);
    chk("rst_valid", {29'h0, vld_a, vld_b, vld_c}, 32'h0);
    chk("rst_ready", {29'h0, rdy_a, rdy_b, rdy_c}, 32'h0);
    chk("rst_busy", {29'h0, bsy_a, bsy_b, bsy_c}, 32'h7);

    // Initial clear takes exactly 16 edges after release
    rst_n = 1'b1;
    ready_count("init_ready");
    chk("init_busy", {29'h0, bsy_a, bsy_b, bsy_c}, 32'h0);

    // First read: latency 1 for A and C, 2 for B
    drive(1'b0, 2'b00, 4'h0, 16'h0);
    push(8'h00, 8'h00, 16'h0000);
    tick();
    cs = 1'b0;
    chk("lat1_a_valid", {31'h0, vld_a}, 32'd1);
    chk("lat1_b_quiet", {31'h0, vld_b}, 32'd0);
    tick();
    chk("lat2_b_valid", {31'h0, vld_b}, 32'd1);
    chk("lat2_a_quiet", {31'h0, vld_a}, 32'd0);

    // Back-to-back vector table
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].din);
      push(vecs[i].ea, vecs[i].eb, vecs[i].ec);
      tick();
    end
    cs = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("hold_dout_a", {24'h0, dout_a}, 32'h00);
    chk("hold_dout_c", {16'h0, dout_c}, 32'h5A00);
    chk("table_drained", qa.size() + qb.size() + qc.size(), 32'd0);

    // Clear request with an access in B's output pipeline and a same-cycle write
    drive(1'b0, 2'b00, 4'h4, 16'h0);
    push(8'hAA, 8'hAA, 16'h12AA);
    tick();
    drive(1'b1, 2'b11, 4'h4, 16'h7777);
    clear_req = 1'b1;
    qb.push_back(8'h00);
    void'(qb.pop_back());
    tick();
    clear_req = 1'b0;
    drive(1'b0, 2'b00, 4'h4, 16'h0);
    chk("clr_busy", {29'h0, bsy_a, bsy_b, bsy_c}, 32'h7);
    ready_count("clr_ready");
    cs = 1'b0;
    chk("clr_drained", qa.size() + qb.size() + qc.size(), 32'd0);

    // Everything reads CLEAR_VAL afterwards
    drive(1'b0, 2'b00, 4'h4, 16'h0); push(8'h00, 8'h00, 16'h0000); tick();
    drive(1'b0, 2'b00, 4'h5, 16'h0); push(8'h00, 8'h00, 16'h0000); tick();
    drive(1'b0, 2'b00, 4'h7, 16'h0); push(8'h00, 8'h00, 16'h0000); tick();
    drive(1'b0, 2'b00, 4'h2, 16'h0); push(8'h00, 8'h00, 16'h0000); tick();
    drive(1'b0, 2'b00, 4'hF, 16'h0); push(8'h00, 8'h00, 16'h0000); tick();
    cs = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("post_clr_drained", qa.size() + qb.size() + qc.size(), 32'd0);

    // Reset at clear cycle 8 restarts the full clear
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst_n = 1'b0;
    tick();
    chk("midclr_rst_busy", {29'h0, bsy_a, bsy_b, bsy_c}, 32'h7);
    rst_n = 1'b1;
    ready_count("midclr_ready");

    // Reset discards a read still in B's output pipeline
    drive(1'b0, 2'b00, 4'h5, 16'h0);
    qa.push_back(8'h00);
    qc.push_back(16'h0000);
    tick();
    cs = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("flush_b_valid", {31'h0, vld_b}, 32'd0);
    chk("flush_b_dout", {24'h0, dout_b}, 32'h0);
    rst_n = 1'b1;
    ready_count("flush_ready");
    chk("final_drained", qa.size() + qb.size() + qc.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
